// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch constants, BTB counter encodings and helpers
package fetch_pkg;

  localparam logic [31:0] FETCH_NOP_INST  = 32'h0000_0013;
  localparam int          FETCH_BTB_IDX_W = 4;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_STRONG_NT = 2'b00;
  localparam ctr_t CTR_WEAK_NT   = 2'b01;
  localparam ctr_t CTR_WEAK_T    = 2'b10;
  localparam ctr_t CTR_STRONG_T  = 2'b11;

  typedef enum logic [2:0] {
    SRC_TRAP,
    SRC_MISP,
    SRC_EARLY,
    SRC_HOLD,
    SRC_PRED,
    SRC_SEQ
  } npc_src_e;

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == CTR_STRONG_T) ? c : c + 2'd1;
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == CTR_STRONG_NT) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// rtl/fetch_btb.sv - direct-mapped BTB, combinational lookup, synchronous update
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int IDX_W = FETCH_BTB_IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        lookup_taken,
  output logic [31:0] lookup_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic             valid_q  [N];
  logic [TAG_W-1:0] tag_q    [N];
  logic [31:0]      target_q [N];
  ctr_t             ctr_q    [N];

  logic [IDX_W-1:0] lidx, uidx;
  logic [TAG_W-1:0] ltag, utag;
  logic             lhit, uhit;
  logic             unused_pc_lsbs;

  assign lidx = lookup_pc[IDX_W+1:2];
  assign ltag = lookup_pc[31:IDX_W+2];
  assign uidx = upd_pc[IDX_W+1:2];
  assign utag = upd_pc[31:IDX_W+2];
  assign unused_pc_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

  // Lookup reads the registered arrays, so a same-edge update is not visible yet.
  assign lhit          = valid_q[lidx] && (tag_q[lidx] == ltag);
  assign lookup_taken  = lhit && ctr_q[lidx][1];
  assign lookup_target = target_q[lidx];
  assign uhit          = valid_q[uidx] && (tag_q[uidx] == utag);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WEAK_NT;
      end
    end else if (upd_valid) begin
      if (upd_taken) begin
        if (uhit) begin
          target_q[uidx] <= upd_target;
          ctr_q[uidx]    <= ctr_inc(ctr_q[uidx]);
        end else begin
          // Taken miss evicts whatever occupies the slot.
          valid_q[uidx]  <= 1'b1;
          tag_q[uidx]    <= utag;
          target_q[uidx] <= upd_target;
          ctr_q[uidx]    <= CTR_WEAK_T;
        end
      end else if (uhit) begin
        ctr_q[uidx] <= ctr_dec(ctr_q[uidx]);
      end
    end
  end

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage: PC, next-PC select, decode pipe registers
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BTB_IDX_W = FETCH_BTB_IDX_W,
  parameter logic [31:0] NOP_INST  = FETCH_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        keep,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        trap_redirect,
  input  logic [31:0] trap_PC,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_PC,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  input  logic        resolve_mispredict,
  input  logic [31:0] resolve_redirect_PC,
  input  logic        branch_PC_early_contral,
  input  logic [31:0] branch_PC_early,
  output logic [31:0] PC_pype0,
  output logic [31:0] PCp4_pype0,
  output logic [31:0] Instraction_pype,
  output logic        is_branch_predict_pype0,
  output logic [31:0] mispredict_count
);

  logic [31:0] pc_q, pc_next, pc_plus4, pred_target;
  logic        pred_taken, squash;
  npc_src_e    src;

  assign imem_addr = pc_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign squash    = trap_redirect | resolve_mispredict | branch_PC_early_contral;

  fetch_btb #(
    .IDX_W(BTB_IDX_W)
  ) u_btb (
    .clk          (clk),
    .rst          (rst),
    .lookup_pc    (pc_q),
    .lookup_taken (pred_taken),
    .lookup_target(pred_target),
    .upd_valid    (resolve_valid),
    .upd_pc       (resolve_PC),
    .upd_taken    (resolve_taken),
    .upd_target   (resolve_target)
  );

  always_comb begin
    src = SRC_SEQ;
    if (trap_redirect)                src = SRC_TRAP;
    else if (resolve_mispredict)      src = SRC_MISP;
    else if (branch_PC_early_contral) src = SRC_EARLY;
    else if (keep)                    src = SRC_HOLD;
    else if (pred_taken)              src = SRC_PRED;
  end

  always_comb begin
    pc_next = pc_plus4;
    case (src)
      SRC_TRAP:  pc_next = trap_PC;
      SRC_MISP:  pc_next = resolve_redirect_PC;
      SRC_EARLY: pc_next = branch_PC_early;
      SRC_HOLD:  pc_next = pc_q;
      SRC_PRED:  pc_next = pred_target;
      default:   pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_next;
  end

  // Redirects squash the slot even while decode is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC_pype0                <= '0;
      PCp4_pype0              <= '0;
      Instraction_pype        <= NOP_INST;
      is_branch_predict_pype0 <= 1'b0;
    end else if (squash) begin
      PC_pype0                <= '0;
      PCp4_pype0              <= '0;
      Instraction_pype        <= NOP_INST;
      is_branch_predict_pype0 <= 1'b0;
    end else if (!keep) begin
      PC_pype0                <= pc_q;
      PCp4_pype0              <= pc_plus4;
      Instraction_pype        <= imem_rdata;
      is_branch_predict_pype0 <= pred_taken;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mispredict_count <= '0;
    else if (resolve_mispredict && (mispredict_count != 32'hFFFF_FFFF))
      mispredict_count <= mispredict_count + 32'd1;
  end

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - directed bench for fetch with a behavioural next-PC/BTB model
module tb_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] IOFS = 32'h1000_0000;

  logic        clk, rst, keep;
  logic [31:0] imem_addr, imem_rdata;
  logic        trap_redirect, resolve_valid, resolve_taken, resolve_mispredict;
  logic        branch_PC_early_contral;
  logic [31:0] trap_PC, resolve_PC, resolve_target, resolve_redirect_PC, branch_PC_early;
  logic [31:0] PC_pype0, PCp4_pype0, Instraction_pype, mispredict_count;
  logic        is_branch_predict_pype0;

  int n_pass = 0;
  int n_total = 0;

  fetch dut (
    .clk(clk), .rst(rst), .keep(keep),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .trap_redirect(trap_redirect), .trap_PC(trap_PC),
    .resolve_valid(resolve_valid), .resolve_PC(resolve_PC),
    .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .resolve_mispredict(resolve_mispredict), .resolve_redirect_PC(resolve_redirect_PC),
    .branch_PC_early_contral(branch_PC_early_contral), .branch_PC_early(branch_PC_early),
    .PC_pype0(PC_pype0), .PCp4_pype0(PCp4_pype0), .Instraction_pype(Instraction_pype),
    .is_branch_predict_pype0(is_branch_predict_pype0), .mispredict_count(mispredict_count)
  );

  assign imem_rdata = imem_addr + IOFS;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Behavioural model: BTB as plain arrays with integer counters.
  logic        m_init = 0;
  logic [31:0] m_pc, m_pcq, m_pcp4, m_inst, m_cnt, m_nxt;
  logic        m_pred, m_hit, m_rhit, m_pt;
  logic        m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int          m_li, m_ri;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc = 0; m_pcq = 0; m_pcp4 = 0; m_inst = NOP; m_pred = 0; m_cnt = 0;
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
      m_init = 1;
    end else begin
      m_li  = int'(m_pc[5:2]);
      m_hit = m_valid[m_li] && (m_tag[m_li] == m_pc[31:6]);
      m_pt  = m_hit && (m_ctr[m_li] >= 2);
      if (trap_redirect)                m_nxt = trap_PC;
      else if (resolve_mispredict)      m_nxt = resolve_redirect_PC;
      else if (branch_PC_early_contral) m_nxt = branch_PC_early;
      else if (keep)                    m_nxt = m_pc;
      else if (m_pt)                    m_nxt = m_tgt[m_li];
      else                              m_nxt = m_pc + 4;
      if (trap_redirect || resolve_mispredict || branch_PC_early_contral) begin
        m_pcq = 0; m_pcp4 = 0; m_inst = NOP; m_pred = 0;
      end else if (!keep) begin
        m_pcq = m_pc; m_pcp4 = m_pc + 4; m_inst = m_pc + IOFS; m_pred = m_pt;
      end
      if (resolve_valid) begin
        m_ri   = int'(resolve_PC[5:2]);
        m_rhit = m_valid[m_ri] && (m_tag[m_ri] == resolve_PC[31:6]);
        if (resolve_taken && m_rhit) begin
          m_tgt[m_ri] = resolve_target;
          if (m_ctr[m_ri] < 3) m_ctr[m_ri]++;
        end else if (resolve_taken) begin
          m_valid[m_ri] = 1; m_tag[m_ri] = resolve_PC[31:6];
          m_tgt[m_ri] = resolve_target; m_ctr[m_ri] = 2;
        end else if (m_rhit && m_ctr[m_ri] > 0) begin
          m_ctr[m_ri]--;
        end
      end
      if (resolve_mispredict && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      m_pc = m_nxt;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("PC_pype0", PC_pype0, m_pcq);
      chk("PCp4_pype0", PCp4_pype0, m_pcp4);
      chk("Instraction_pype", Instraction_pype, m_inst);
      chk("is_branch_predict_pype0", {31'b0, is_branch_predict_pype0}, {31'b0, m_pred});
      chk("mispredict_count", mispredict_count, m_cnt);
    end
  end

  task automatic clr();
    keep = 0; trap_redirect = 0; trap_PC = 0;
    resolve_valid = 0; resolve_PC = 0; resolve_taken = 0; resolve_target = 0;
    resolve_mispredict = 0; resolve_redirect_PC = 0;
    branch_PC_early_contral = 0; branch_PC_early = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    resolve_valid = 1; resolve_PC = pc; resolve_taken = tk; resolve_target = tgt;
  endtask

  task automatic early(input logic [31:0] tgt);
    branch_PC_early_contral = 1; branch_PC_early = tgt;
  endtask

  initial begin
    rst = 0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("lit_rst_addr", imem_addr, 32'h0);
    chk("lit_rst_inst", Instraction_pype, NOP);
    rst = 1;

    step();
    chk("lit_first_addr", imem_addr, 32'h4);
    chk("lit_first_pc", PC_pype0, 32'h0);
    chk("lit_first_inst", Instraction_pype, 32'h1000_0000);
    step();
    chk("lit_second_addr", imem_addr, 32'h8);

    keep = 1;
    repeat (3) step();
    chk("lit_keep_addr", imem_addr, 32'h8);
    chk("lit_keep_pc", PC_pype0, 32'h4);
    keep = 0;
    step();
    chk("lit_resume_pc", PC_pype0, 32'h8);
    chk("lit_resume_addr", imem_addr, 32'hC);

    resolve(32'h10, 1, 32'h40);
    step(); clr();
    chk("lit_alloc_addr", imem_addr, 32'h10);
    step();
    chk("lit_pred_addr", imem_addr, 32'h40);
    chk("lit_pred_pc", PC_pype0, 32'h10);
    chk("lit_pred_flag", {31'b0, is_branch_predict_pype0}, 32'h1);

    resolve(32'h10, 0, 32'h0);
    repeat (3) step();
    clr();
    early(32'h10);
    step(); clr();
    chk("lit_early_addr", imem_addr, 32'h10);
    chk("lit_early_inst", Instraction_pype, NOP);
    chk("lit_early_pc", PC_pype0, 32'h0);

    resolve(32'h10, 1, 32'h40);
    step();
    chk("lit_floor_addr", imem_addr, 32'h14);
    step(); clr();
    early(32'h10);
    step(); clr();
    resolve(32'h10, 0, 32'h0);
    step(); clr();
    chk("lit_same_cycle_addr", imem_addr, 32'h40);

    trap_redirect = 1; trap_PC = 32'h100;
    resolve_mispredict = 1; resolve_redirect_PC = 32'h200; keep = 1;
    step(); clr();
    chk("lit_trap_addr", imem_addr, 32'h100);
    chk("lit_trap_inst", Instraction_pype, NOP);
    chk("lit_trap_cnt", mispredict_count, 32'h1);
    step();
    chk("lit_after_trap_pc", PC_pype0, 32'h100);

    trap_redirect = 1; trap_PC = 32'hFFFF_FFFC;
    step(); clr();
    step();
    chk("lit_wrap_addr", imem_addr, 32'h0);
    chk("lit_wrap_pcp4", PCp4_pype0, 32'h0);

    resolve_mispredict = 1; resolve_redirect_PC = 32'h80;
    resolve(32'h4, 1, 32'h80);
    step(); clr();
    chk("lit_misp_addr", imem_addr, 32'h80);
    chk("lit_misp_cnt", mispredict_count, 32'h2);
    early(32'h4);
    step(); clr();
    step();
    chk("lit_pred4_addr", imem_addr, 32'h80);
    step();
    step();
    chk("lit_tag_miss_addr", imem_addr, 32'h88);

    #2 rst = 0;
    #1;
    chk("lit_async_addr", imem_addr, 32'h0);
    chk("lit_async_pc", PC_pype0, 32'h0);
    chk("lit_async_inst", Instraction_pype, NOP);
    chk("lit_async_cnt", mispredict_count, 32'h0);
    @(posedge clk);
    #1 rst = 1;
    step();
    chk("lit_restart_addr", imem_addr, 32'h4);
    step();
    chk("lit_btb_cleared_addr", imem_addr, 32'h8);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
